bsr_block_sequencer: RTL and testbench

//  Sequences one output tile on the 14x14 sparse weight-stationary array. Consumes BSR block

---
 rtl/bsr_block_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_bsr_block_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_block_sequencer.sv
// Per-tile sequencer for the sparse weight-stationary array: walks BSR block descriptors
// through clear / weight load / activation stream / flush and holds the result for the consumer.
module bsr_block_sequencer #(
  parameter int N_ROWS  = 14,
  parameter int N_COLS  = 14,
  parameter int ACT_LEN = 14,
  parameter int WADDR_W = 16,
  parameter int AADDR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [WADDR_W-1:0] desc_blk_idx,
  input  logic [AADDR_W-1:0] desc_act_base,
  input  logic               desc_zero,
  input  logic               desc_last,
  output logic               wt_rd_en,
  output logic [WADDR_W-1:0] wt_rd_addr,
  output logic               act_rd_en,
  output logic [AADDR_W-1:0] act_rd_addr,
  output logic               act_flush,
  output logic               load_weight,
  output logic               block_valid,
  output logic               clr,
  output logic               tile_valid,
  input  logic               tile_ack,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_issued,
  output logic [CNT_W-1:0]   blk_skipped
);

  // state  | meaning
  // IDLE   | waiting for a descriptor (only state with desc_ready)
  // CLR    | first block of a tile: clear accumulators
  // SKIP   | all-zero block, nothing sent to the array
  // LOAD   | weight rows fetched and latched, N_ROWS+1 cycles
  // STREAM | activations streamed, then skew/PE pipeline flushed
  // DONE   | tile result held until tile_ack
  typedef enum logic [2:0] {IDLE, CLR, SKIP, LOAD, STREAM, DONE} state_t;

  localparam int FLUSH      = N_ROWS + N_COLS - 2;
  localparam int STREAM_LEN = ACT_LEN + FLUSH + 1;
  localparam int TMR_MAX    = (STREAM_LEN > N_ROWS + 1) ? STREAM_LEN : N_ROWS + 1;
  localparam int TMR_W      = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] LOAD_TC   = TMR_W'(N_ROWS);
  localparam logic [TMR_W-1:0] STREAM_TC = TMR_W'(STREAM_LEN - 1);
  localparam logic [TMR_W-1:0] FLUSH_TC  = TMR_W'(FLUSH);

  state_t             state, state_n;
  logic [TMR_W-1:0]   remain, remain_n;
  logic               tile_open, tile_open_n;
  logic               d_zero, d_last;
  logic [WADDR_W-1:0] wt_base, wt_base_sel;
  logic [AADDR_W-1:0] act_base;
  logic               latch, inc_issued, inc_skipped;

  logic               desc_ready_n, busy_n, clr_n, tile_valid_n;
  logic               wt_rd_en_n, load_weight_n, act_rd_en_n, block_valid_n, act_flush_n;
  logic [WADDR_W-1:0] wt_rd_addr_n;
  logic [AADDR_W-1:0] act_rd_addr_n;
  logic [CNT_W-1:0]   blk_issued_n, blk_skipped_n;
  logic               in_load, in_stream;

  always_comb begin
    state_n     = state;
    remain_n    = remain;
    tile_open_n = tile_open;
    latch       = 1'b0;
    inc_issued  = 1'b0;
    inc_skipped = 1'b0;
    unique case (state)
      IDLE: begin
        if (desc_valid && desc_ready) begin
          latch = 1'b1;
          if (!tile_open) begin
            state_n = CLR;
          end else if (desc_zero) begin
            state_n = SKIP;
          end else begin
            state_n  = LOAD;
            remain_n = LOAD_TC;
          end
        end
      end
      CLR: begin
        tile_open_n = 1'b1;
        if (d_zero) begin
          state_n = SKIP;
        end else begin
          state_n  = LOAD;
          remain_n = LOAD_TC;
        end
      end
      SKIP: begin
        inc_skipped = 1'b1;
        state_n     = d_last ? DONE : IDLE;
      end
      LOAD: begin
        if (remain == '0) begin
          state_n  = STREAM;
          remain_n = STREAM_TC;
        end else begin
          remain_n = remain - TMR_W'(1);
        end
      end
      STREAM: begin
        if (remain == '0) begin
          inc_issued = 1'b1;
          state_n    = d_last ? DONE : IDLE;
        end else begin
          remain_n = remain - TMR_W'(1);
        end
      end
      DONE: begin
        if (tile_ack && tile_valid) begin
          state_n     = IDLE;
          tile_open_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state and timer value.
  always_comb begin
    wt_base_sel   = latch ? WADDR_W'(desc_blk_idx * WADDR_W'(N_ROWS)) : wt_base;
    in_load       = (state_n == LOAD);
    in_stream     = (state_n == STREAM);
    desc_ready_n  = (state_n == IDLE);
    busy_n        = (state_n != IDLE);
    clr_n         = (state_n == CLR);
    tile_valid_n  = (state_n == DONE);
    wt_rd_en_n    = in_load && (remain_n != '0);
    load_weight_n = in_load && (remain_n != LOAD_TC);
    act_rd_en_n   = in_stream && (remain_n > FLUSH_TC);
    block_valid_n = in_stream && (remain_n != STREAM_TC);
    act_flush_n   = in_stream && (remain_n < FLUSH_TC);
    wt_rd_addr_n  = '0;
    act_rd_addr_n = '0;
    if (wt_rd_en_n) begin
      wt_rd_addr_n = wt_base_sel + WADDR_W'(LOAD_TC - remain_n);
    end
    if (act_rd_en_n) begin
      act_rd_addr_n = act_base + AADDR_W'(STREAM_TC - remain_n);
    end
    blk_issued_n  = blk_issued;
    blk_skipped_n = blk_skipped;
    if (inc_issued && (blk_issued != '1)) begin
      blk_issued_n = blk_issued + CNT_W'(1);
    end
    if (inc_skipped && (blk_skipped != '1)) begin
      blk_skipped_n = blk_skipped + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remain      <= '0;
      tile_open   <= 1'b0;
      d_zero      <= 1'b0;
      d_last      <= 1'b0;
      wt_base     <= '0;
      act_base    <= '0;
      desc_ready  <= 1'b0;
      busy        <= 1'b0;
      clr         <= 1'b0;
      tile_valid  <= 1'b0;
      wt_rd_en    <= 1'b0;
      wt_rd_addr  <= '0;
      load_weight <= 1'b0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      block_valid <= 1'b0;
      act_flush   <= 1'b0;
      blk_issued  <= '0;
      blk_skipped <= '0;
    end else begin
      state       <= state_n;
      remain      <= remain_n;
      tile_open   <= tile_open_n;
      if (latch) begin
        d_zero   <= desc_zero;
        d_last   <= desc_last;
        wt_base  <= wt_base_sel;
        act_base <= desc_act_base;
      end
      desc_ready  <= desc_ready_n;
      busy        <= busy_n;
      clr         <= clr_n;
      tile_valid  <= tile_valid_n;
      wt_rd_en    <= wt_rd_en_n;
      wt_rd_addr  <= wt_rd_addr_n;
      load_weight <= load_weight_n;
      act_rd_en   <= act_rd_en_n;
      act_rd_addr <= act_rd_addr_n;
      block_valid <= block_valid_n;
      act_flush   <= act_flush_n;
      blk_issued  <= blk_issued_n;
      blk_skipped <= blk_skipped_n;
    end
  end

endmodule

// File: tb/tb_bsr_block_sequencer.sv
// Bench for bsr_block_sequencer: per-descriptor timelines are queued by the driver and
// compared cycle by cycle by an independent monitor.
module tb_bsr_block_sequencer;
  localparam int N_ROWS  = 14;
  localparam int N_COLS  = 14;
  localparam int ACT_LEN = 14;
  localparam int FLUSH   = N_ROWS + N_COLS - 2;
  localparam int SLEN    = ACT_LEN + FLUSH + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [15:0] desc_blk_idx = '0;
  logic [15:0] desc_act_base = '0;
  logic        desc_zero = 1'b0;
  logic        desc_last = 1'b0;
  logic        wt_rd_en, act_rd_en, act_flush, load_weight, block_valid, clr, tile_valid, busy;
  logic [15:0] wt_rd_addr, act_rd_addr, blk_issued, blk_skipped;
  logic        tile_ack = 1'b0;

  bsr_block_sequencer #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .ACT_LEN(ACT_LEN),
    .WADDR_W(16), .AADDR_W(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_blk_idx(desc_blk_idx), .desc_act_base(desc_act_base),
    .desc_zero(desc_zero), .desc_last(desc_last),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .act_flush(act_flush), .load_weight(load_weight),
    .block_valid(block_valid), .clr(clr),
    .tile_valid(tile_valid), .tile_ack(tile_ack), .busy(busy),
    .blk_issued(blk_issued), .blk_skipped(blk_skipped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        clr, wt_en, lw, act_en, bv, fl, tv;
    logic [15:0] wt_addr, act_addr;
    logic        inc_i, inc_s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   in_reset = 1'b1;
  int   rdy_low_cyc = -1;
  bit   tile_open_m = 1'b0;
  int   exp_i = 0;
  int   exp_s = 0;

  function automatic exp_t mk(input int c);
    exp_t r;
    r.cyc = c; r.clr = 0; r.wt_en = 0; r.lw = 0; r.act_en = 0; r.bv = 0; r.fl = 0; r.tv = 0;
    r.wt_addr = '0; r.act_addr = '0; r.inc_i = 0; r.inc_s = 0;
    return r;
  endfunction

  // Monitor: one expected record per busy cycle; any cycle without a record must look idle.
  always @(negedge clk) begin : monitor
    exp_t       e;
    exp_t       stale;
    bit         busy_e, ok;
    logic [8:0] act_v, exp_v;
    if (in_reset) begin
      sb.delete();
      exp_i = 0;
      exp_s = 0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        stale = sb.pop_front();
        checks++; errors++;
        $display("FAIL stale_record cyc=%0d record_cyc=%0d", cyc, stale.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        busy_e = 1'b1;
      end else begin
        e = mk(cyc);
        busy_e = 1'b0;
      end
      exp_v = {!busy_e && (cyc != rdy_low_cyc), busy_e, e.clr, e.wt_en, e.lw, e.act_en, e.bv, e.fl, e.tv};
      act_v = {desc_ready, busy, clr, wt_rd_en, load_weight, act_rd_en, block_valid, act_flush, tile_valid};
      ok = (act_v === exp_v);
      if (e.wt_en && wt_rd_addr !== e.wt_addr) ok = 1'b0;
      if (e.act_en && act_rd_addr !== e.act_addr) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL outputs cyc=%0d rdy/busy/clr/wt/lw/act/bv/fl/tv actual=%b wt=%h act=%h required=%b wt=%h act=%h",
                 cyc, act_v, wt_rd_addr, act_rd_addr, exp_v, e.wt_addr, e.act_addr);
      end
      checks++;
      if (blk_issued !== 16'(exp_i) || blk_skipped !== 16'(exp_s)) begin
        errors++;
        $display("FAIL counters cyc=%0d actual issued=%0d skipped=%0d required issued=%0d skipped=%0d",
                 cyc, blk_issued, blk_skipped, exp_i, exp_s);
      end
      if (e.inc_i && exp_i < 65535) exp_i++;
      if (e.inc_s && exp_s < 65535) exp_s++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    logic [8:0] v;
    in_reset = 1'b1;
    rst = 1'b1;
    desc_valid = 1'b0;
    tile_ack = 1'b0;
    #1;
    v = {desc_ready, busy, clr, wt_rd_en, load_weight, act_rd_en, block_valid, act_flush, tile_valid};
    checks++;
    if (v !== '0 || wt_rd_addr !== '0 || act_rd_addr !== '0 || blk_issued !== '0 || blk_skipped !== '0) begin
      errors++;
      $display("FAIL reset_outputs ctl=%b wt=%h act=%h issued=%0d skipped=%0d required all zero",
               v, wt_rd_addr, act_rd_addr, blk_issued, blk_skipped);
    end
    tile_open_m = 1'b0;
    repeat (hold) tick();
    rst = 1'b0;
    rdy_low_cyc = cyc;
    in_reset = 1'b0;
  endtask

  // Issue one descriptor, queue the timeline it must produce, and for a last block drive the ack.
  task automatic send(input int blk, input int base, input bit zero, input bit last,
                      input int ack_d, input bit spur, output int hs);
    exp_t r;
    int   t, s, e_end, ack_c, spur_c;
    desc_blk_idx  = 16'(blk);
    desc_act_base = 16'(base);
    desc_zero     = zero;
    desc_last     = last;
    desc_valid    = 1'b1;
    tile_ack      = 1'b0;
    hs = -1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (desc_ready === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      checks++; errors++;
      $display("FAIL handshake_timeout cyc=%0d desc_ready=%b required 1 within 300 cycles", cyc, desc_ready);
      tick();
      desc_valid = 1'b0;
      return;
    end
    t = hs + 1;
    if (!tile_open_m) begin
      r = mk(t); r.clr = 1; sb.push_back(r);
      t++;
      tile_open_m = 1'b1;
    end
    if (zero) begin
      r = mk(t); r.inc_s = 1; sb.push_back(r);
      e_end = t;
    end else begin
      for (int k = 0; k <= N_ROWS; k++) begin
        r = mk(t + k);
        r.wt_en = (k < N_ROWS);
        r.wt_addr = r.wt_en ? 16'(blk * N_ROWS + k) : 16'h0;
        r.lw = (k >= 1);
        sb.push_back(r);
      end
      s = t + N_ROWS + 1;
      for (int k = 0; k < SLEN; k++) begin
        r = mk(s + k);
        r.act_en = (k < ACT_LEN);
        r.act_addr = r.act_en ? 16'(base + k) : 16'h0;
        r.bv = (k >= 1);
        r.fl = (k >= ACT_LEN + 1);
        r.inc_i = (k == SLEN - 1);
        sb.push_back(r);
      end
      e_end = s + SLEN - 1;
    end
    if (last) begin
      for (int k = 0; k <= ack_d; k++) begin
        r = mk(e_end + 1 + k); r.tv = 1; sb.push_back(r);
      end
      tile_open_m = 1'b0;
    end
    tick();
    desc_valid    = 1'b0;
    desc_blk_idx  = 16'($urandom);
    desc_act_base = 16'($urandom);
    desc_zero     = 1'($urandom);
    desc_last     = 1'($urandom);
    if (last) begin
      ack_c  = e_end + 1 + ack_d;
      spur_c = $urandom_range(e_end, hs + 1);
      while (cyc <= ack_c) begin
        tile_ack = (cyc == ack_c) || (spur && cyc == spur_c);
        tick();
      end
      tile_ack = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d simulation did not complete in time", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int hs;
    int nblk;
    tick();
    do_reset(3);
    tick();
    // Reference block: idx 2, base 0x40, nonzero, last.
    send(2, 'h40, 1'b0, 1'b1, 0, 1'b0, hs);
    // Zero block followed by a nonzero last block, back to back.
    send(9, 'h11, 1'b1, 1'b0, 0, 1'b0, hs);
    send(7, 'h100, 1'b0, 1'b1, 2, 1'b1, hs);
    // Single zero+last tile.
    send(5, 'h0, 1'b1, 1'b1, 0, 1'b0, hs);
    // Consumer stalls ten cycles before acknowledging.
    send(1, 'h10, 1'b0, 1'b1, 10, 1'b1, hs);
    // Address wrap on both RAMs.
    send('hFFFF, 'hFFFA, 1'b0, 1'b1, 1, 1'b0, hs);
    // Reset in the middle of the stream, then a fresh tile must clear again.
    send(3, 'h20, 1'b0, 1'b0, 0, 1'b0, hs);
    while (cyc < hs + 2 + N_ROWS + 1 + 5) tick();
    do_reset(2);
    send(4, 'h30, 1'b0, 1'b1, 0, 1'b0, hs);
    // Randomized tiles with idle gaps and stray acks while no result is held.
    for (int tl = 0; tl < 25; tl++) begin
      nblk = $urandom_range(4, 1);
      for (int b = 0; b < nblk; b++) begin
        repeat ($urandom_range(3, 0)) begin
          tile_ack = 1'($urandom);
          tick();
        end
        tile_ack = 1'b0;
        send(int'($urandom_range(16'hFFFF, 0)), int'($urandom_range(16'hFFFF, 0)),
             ($urandom_range(2, 0) == 0), (b == nblk - 1),
             $urandom_range(5, 0), 1'($urandom), hs);
      end
    end
    repeat (6) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
